// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end for a shared Booth multiplier datapath.
// Requesters hand over operand pairs, one operation is in flight at a time,
// and the product (or a timeout error) is returned to the originating requester.
module mul_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]   req_multiplicand_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_multiplier_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  input  logic [NUM_REQ-1:0]         rsp_ready_i,
  output logic [2*WIDTH-1:0]         rsp_product_o,
  output logic                       rsp_error_o,
  output logic                       mul_start_o,
  output logic [WIDTH-1:0]           mul_multiplicand_o,
  output logic [WIDTH-1:0]           mul_multiplier_o,
  input  logic                       mul_done_i,
  input  logic [2*WIDTH-1:0]         mul_product_i,
  output logic                       busy_o
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int WDW  = $clog2(TIMEOUT) + 1;

  // Watchdog value in the last WAIT cycle before the operation is abandoned.
  localparam logic [WDW-1:0]     WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0]    PTR_RST = IDXW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic [IDXW-1:0]      gnt_q, gnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 error_q, error_d;
  logic [WDW-1:0]       wdog_q, wdog_d;
  logic [IDXW-1:0]      gnt_pick;
  logic [NUM_REQ-1:0]   req_ready;

  // First valid requester strictly after the last served one, with wrap-around.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [IDXW-1:0]    ptr);
    logic [IDXW-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx[IDXW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDXW-1:0];
      end
    end
    return pick;
  endfunction

  // Round-robin candidate for this cycle (only acted upon in IDLE).
  always_comb begin
    gnt_pick = rr_pick(req_valid_i, ptr_q);
  end

  // Next-state logic: grant, issue, watchdog wait, capture and response hold.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
    error_d   = error_q;
    wdog_d    = wdog_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        // No handshake while reset is asserted, so a request is never lost.
        if (rst_n && (|req_valid_i)) begin
          req_ready = ONE_HOT0 << gnt_pick;
          gnt_d     = gnt_pick;
          mcand_d   = req_multiplicand_i[int'(gnt_pick)*WIDTH +: WIDTH];
          mplier_d  = req_multiplier_i[int'(gnt_pick)*WIDTH +: WIDTH];
          state_d   = S_ISSUE;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + {{(WDW-1){1'b0}}, 1'b1};
        // A done in the final watchdog cycle still wins over the timeout.
        if (mul_done_i) begin
          state_d = S_CAPTURE;
        end else if (wdog_q == WD_LAST) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = S_RESP;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_CAPTURE: begin
        result_d = mul_product_i;
        error_d  = 1'b0;
        state_d  = S_RESP;
      end
      S_RESP: begin
        // Only the granted requester's ready completes the response.
        if (rsp_ready_i[gnt_q]) begin
          ptr_d   = gnt_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= PTR_RST;
      gnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      error_q  <= error_d;
      wdog_q   <= wdog_d;
    end
  end

  // Outputs decoded from registered state only, except the combinational grant.
  always_comb begin
    req_ready_o        = req_ready;
    busy_o             = (state_q != S_IDLE);
    mul_start_o        = (state_q == S_ISSUE);
    mul_multiplicand_o = mcand_q;
    mul_multiplier_o   = mplier_q;
    rsp_product_o      = result_q;
    rsp_error_o        = error_q;
    if (state_q == S_RESP) begin
      rsp_valid_o = ONE_HOT0 << gnt_q;
    end else begin
      rsp_valid_o = '0;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: a behavioural multiplier with a chosen
// latency sits behind the DUT, and a transaction-level reference model predicts
// grants, start pulse, response timing, product and error flag every cycle.
module tb_mul_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*W-1:0]   req_multiplicand_i, req_multiplier_i;
  logic [2*W-1:0]   rsp_product_o, mul_product_i;
  logic             rsp_error_o, mul_start_o, mul_done_i, busy_o;
  logic [W-1:0]     mul_multiplicand_o, mul_multiplier_o;

  always #5 clk = ~clk;

  mul_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_multiplicand_i(req_multiplicand_i), .req_multiplier_i(req_multiplier_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_product_o(rsp_product_o), .rsp_error_o(rsp_error_o),
    .mul_start_o(mul_start_o), .mul_multiplicand_o(mul_multiplicand_o),
    .mul_multiplier_o(mul_multiplier_o), .mul_done_i(mul_done_i),
    .mul_product_i(mul_product_i), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Requester operand sources
  logic [W-1:0] a_op [N];
  logic [W-1:0] b_op [N];

  // Behavioural multiplier
  int          mm_done_cyc = -1;
  logic [63:0] mm_prod;
  int          next_lat    = 3;
  bit          done_en     = 1'b1;
  bit          inject_done = 1'b0;

  // Reference model (transaction level)
  bit          m_active;
  int          m_t, m_rsp, m_g, m_ptr;
  logic [W-1:0] m_a, m_b;
  logic [63:0] m_prod;
  logic        m_err;
  int          glog[$];
  int          acc_cyc, start_cnt;

  // Per-operation results of do_op
  logic [63:0] op_prod;
  logic        op_err;
  int          op_lat, op_starts;

  function automatic logic [63:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] ea, eb;
    ea = {{32{a[W-1]}}, a};
    eb = {{32{b[W-1]}}, b};
    return ea * eb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic rst_v, input logic [N-1:0] v, input logic [N-1:0] r);
    int pick, idx;
    logic [N-1:0] e_ready, e_rv;
    @(posedge clk);
    #1;
    cyc++;
    rst_n       = rst_v;
    req_valid_i = v;
    rsp_ready_i = r;
    for (int i = 0; i < N; i++) begin
      req_multiplicand_i[i*W +: W] = a_op[i];
      req_multiplier_i[i*W +: W]   = b_op[i];
    end
    mul_done_i = (cyc == mm_done_cyc) || inject_done;
    if (cyc == mm_done_cyc) mul_product_i = mm_prod;
    #1;
    pick = -1;
    if (!m_active && rst_v) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (pick < 0 && v[idx]) pick = idx;
      end
    end
    e_ready = (pick >= 0) ? (4'b0001 << pick) : 4'b0000;
    e_rv    = (m_active && cyc >= m_rsp) ? (4'b0001 << m_g) : 4'b0000;
    chk("req_ready", req_ready_o, e_ready);
    chk("busy", busy_o, m_active);
    chk("mul_start", mul_start_o, m_active && (cyc == m_t + 1));
    chk("rsp_valid", rsp_valid_o, e_rv);
    if (e_rv != 4'b0000) begin
      chk("rsp_product", rsp_product_o, m_prod);
      chk("rsp_error", rsp_error_o, m_err);
    end
    if (m_active && cyc > m_t && cyc < m_rsp) begin
      chk("mul_a", mul_multiplicand_o, m_a);
      chk("mul_b", mul_multiplier_o, m_b);
    end
    if (mul_start_o) begin
      start_cnt++;
      mm_prod       = smul(mul_multiplicand_o, mul_multiplier_o);
      mul_product_i = {$urandom, $urandom};
      mm_done_cyc   = done_en ? cyc + next_lat : -1;
    end
    if (!rst_v) begin
      m_active = 1'b0;
      m_ptr    = N - 1;
    end else if (pick >= 0) begin
      m_active = 1'b1;
      m_t      = cyc;
      acc_cyc  = cyc;
      m_g      = pick;
      m_a      = a_op[pick];
      m_b      = b_op[pick];
      if (done_en && next_lat <= TO) begin
        m_rsp  = cyc + 1 + next_lat + 2;
        m_err  = 1'b0;
        m_prod = smul(m_a, m_b);
      end else begin
        m_rsp  = cyc + 2 + TO;
        m_err  = 1'b1;
        m_prod = 64'd0;
      end
      glog.push_back(pick);
      a_op[pick] = $urandom;
      b_op[pick] = $urandom;
    end else if (e_rv != 4'b0000 && r[m_g]) begin
      m_active = 1'b0;
      m_ptr    = m_g;
    end
  endtask

  // Complete one directed operation for requester rq.
  task automatic do_op(input int rq, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int lat, input int hold, input logic [N-1:0] others,
                       input bit inj);
    int n0, budget;
    logic [63:0] p0;
    logic e0;
    logic [N-1:0] rmask;
    rmask = ~(4'b0001 << rq);
    a_op[rq] = a;
    b_op[rq] = b;
    next_lat = lat;
    n0 = glog.size();
    start_cnt = 0;
    budget = 0;
    while (glog.size() == n0 && budget < 8) begin
      cycle(1'b1, 4'b0001 << rq, 4'b0000);
      budget++;
    end
    chk("accept_seen", glog.size() != n0, 1'b1);
    budget = 0;
    while (rsp_valid_o == 4'b0000 && budget < TO + 20) begin
      cycle(1'b1, others, rmask);
      budget++;
    end
    chk("rsp_seen", rsp_valid_o != 4'b0000, 1'b1);
    op_lat = cyc - acc_cyc;
    p0 = rsp_product_o;
    e0 = rsp_error_o;
    op_prod = p0;
    op_err  = e0;
    for (int h = 0; h < hold; h++) begin
      inject_done = inj && (h == 0);
      cycle(1'b1, others, rmask);
      chk("hold_prod", rsp_product_o, p0);
      chk("hold_err", rsp_error_o, e0);
      chk("hold_valid", rsp_valid_o, 4'b0001 << rq);
    end
    inject_done = 1'b0;
    cycle(1'b1, 4'b0000, 4'b0001 << rq);
    op_starts = start_cnt;
    inject_done = inj;
    cycle(1'b1, 4'b0000, 4'b0000);
    inject_done = 1'b0;
    chk("idle_after_rsp", busy_o, 1'b0);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_start"}, mul_start_o, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 4'b0000);
    chk({tag, "_rsp_prod"}, rsp_product_o, 64'd0);
    chk({tag, "_rsp_err"}, rsp_error_o, 1'b0);
    chk({tag, "_mul_a"}, mul_multiplicand_o, 32'd0);
    chk({tag, "_mul_b"}, mul_multiplier_o, 32'd0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (m_active && budget < 200) begin
      cycle(1'b1, 4'b0000, 4'b1111);
      budget++;
    end
    cycle(1'b1, 4'b0000, 4'b0000);
    chk("drain_idle", busy_o, 1'b0);
  endtask

  initial begin
    int base, budget;
    rst_n = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    req_multiplicand_i = '0;
    req_multiplier_i = '0;
    mul_done_i = 1'b0;
    mul_product_i = '0;
    for (int i = 0; i < N; i++) begin
      a_op[i] = $urandom;
      b_op[i] = $urandom;
    end
    m_active = 1'b0;
    m_ptr = N - 1;
    repeat (2) @(posedge clk);

    // Reset state, requests held off while in reset
    cycle(1'b0, 4'b1111, 4'b0000);
    zero_check("reset");
    cycle(1'b1, 4'b0000, 4'b0000);

    // Single op: requester 2, 7 x -3
    do_op(2, 32'd7, 32'hFFFF_FFFD, 4, 0, 4'b0000, 1'b0);
    chk("single_prod", op_prod, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("single_err", op_err, 1'b0);
    chk("single_starts", op_starts, 1);
    chk("single_lat", op_lat, 4 + 3);

    // Extremes: -2^31 x -2^31
    do_op(0, 32'h8000_0000, 32'h8000_0000, 1, 0, 4'b0000, 1'b0);
    chk("extreme_prod", op_prod, 64'h4000_0000_0000_0000);
    chk("extreme_lat", op_lat, 1 + 3);

    // Done in the very last watchdog cycle is still accepted
    do_op(1, $urandom, $urandom, TO, 0, 4'b0000, 1'b0);
    chk("lastcycle_err", op_err, 1'b0);
    chk("lastcycle_lat", op_lat, TO + 3);

    // Timeout with no done; late done injected in RESP and IDLE
    done_en = 1'b0;
    do_op(3, $urandom, $urandom, 5, 3, 4'b0101, 1'b1);
    chk("timeout_err", op_err, 1'b1);
    chk("timeout_prod", op_prod, 64'd0);
    chk("timeout_lat", op_lat, TO + 2);
    done_en = 1'b1;

    // Done one cycle too late arrives while the error response is held
    do_op(2, $urandom, $urandom, TO + 1, 2, 4'b0000, 1'b0);
    chk("late_err", op_err, 1'b1);
    chk("late_lat", op_lat, TO + 2);

    // Backpressure: response held 10 cycles, other requesters waiting
    do_op(3, $urandom, $urandom, 6, 10, 4'b0111, 1'b0);
    chk("bp_err", op_err, 1'b0);

    // Reset in the middle of WAIT, then requesters 1 and 3
    a_op[2] = $urandom | 32'h1;
    b_op[2] = $urandom | 32'h1;
    next_lat = 50;
    budget = 0;
    while (!m_active && budget < 8) begin
      cycle(1'b1, 4'b0100, 4'b0000);
      budget++;
    end
    repeat (5) cycle(1'b1, 4'b0000, 4'b0000);
    chk("midwait_busy", busy_o, 1'b1);
    cycle(1'b0, 4'b0000, 4'b0000);
    next_lat = 3;
    cycle(1'b1, 4'b1010, 4'b0000);
    zero_check("post_rst");
    chk("post_rst_grant", req_ready_o, 4'b0010);
    drain();

    // Round-robin fairness from reset with everyone valid
    cycle(1'b0, 4'b0000, 4'b0000);
    base = glog.size();
    budget = 0;
    while (glog.size() < base + 8 && budget < 400) begin
      if (!m_active) next_lat = $urandom_range(1, 5);
      cycle(1'b1, 4'b1111, 4'b1111);
      budget++;
    end
    chk("rr_count", glog.size() >= base + 8, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("rr_order", (base + k < glog.size()) ? glog[base + k] : -1, k % N);
    end
    drain();

    // Randomized traffic including timeouts and backpressure
    repeat (1500) begin
      if (!m_active) next_lat = $urandom_range(1, 40);
      cycle(1'b1, 4'($urandom), 4'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin controller that shares one radix-16 Booth multiplier datapath (`mul_datapath`) between `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues a one-cycle start to the datapath. It waits for done, with a watchdog timeout, captures the product and returns it to the originating requester over a per-requester response handshake. It sits between the requesting units and the multiplier and is the only block that drives the multiplier's start and operand inputs.

## Interface
- `WIDTH`, 32, operand width; products are `2*WIDTH` bits, two's complement.
- `NUM_REQ`, 4, number of requesters (≥2).
- `TIMEOUT`, 32, maximum number of cycles spent in WAIT before aborting.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid_i`  in  `NUM_REQ`  request valid, one bit per requester.
- `req_ready_o`  out  `NUM_REQ`  request accept; one-hot or zero.
- `req_multiplicand_i`  in  `NUM_REQ*WIDTH`  packed signed multiplicands; requester i is at slice `[i*WIDTH +: WIDTH]`.
- `req_multiplier_i`  in  `NUM_REQ*WIDTH`  packed signed multipliers, same packing.
- `rsp_valid_o`  out  `NUM_REQ`  response valid; one-hot or zero.
- `rsp_ready_i`  in  `NUM_REQ`  response accept, one bit per requester.
- `rsp_product_o`  out  `2*WIDTH`  shared response product; meaningful only while some `rsp_valid_o` bit is high.
- `rsp_error_o`  out  1  response flag; 1 means the operation timed out.
- `mul_start_o`  out  1  start/load pulse to the multiplier.
- `mul_multiplicand_o`  out  `WIDTH`  operand to the multiplier.
- `mul_multiplier_o`  out  `WIDTH`  operand to the multiplier.
- `mul_done_i`  in  1  multiplier done.
- `mul_product_i`  in  `2*WIDTH`  multiplier registered product.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- **IDLE**
  - If any `req_valid_i` bit is high, grant index `g` = first set bit searching from `(ptr+1) mod NUM_REQ` upward, with wrap-around.
  - `req_ready_o[g]`=1 combinationally in that cycle.
  - The handshake completes that cycle. Latch slice `g` of both operand buses and latch `g`, then go to ISSUE.
  - No grant is made in any state other than IDLE.
- **ISSUE**
  - `mul_start_o`=1 for exactly this cycle, then go to WAIT.
  - Clear the watchdog counter.
- **WAIT**
  - The watchdog counter increments each cycle.
  - If `mul_done_i`=1, go to CAPTURE. Only the first done seen in WAIT counts.
  - Otherwise, if the counter reaches `TIMEOUT-1`, go to RESP with error=1 and product=0.
- **CAPTURE**
  - Register `mul_product_i` into the result register and set error=0, then go to RESP.
- **RESP**
  - `rsp_valid_o[g]`=1.
  - `rsp_product_o` and `rsp_error_o` are driven from registers and held stable until `rsp_ready_i[g]`=1.
  - On that handshake: set `ptr` to `g`, return to IDLE, and drop `rsp_valid_o` in the following cycle.
  - `rsp_ready_i` bits other than `g` are ignored.
- `mul_multiplicand_o` and `mul_multiplier_o` are driven from the latched operand registers and are stable from ISSUE through CAPTURE.
- `mul_done_i` is ignored in IDLE, ISSUE, CAPTURE and RESP. This covers a late done arriving after a timeout.
- The product is passed through unmodified; the controller performs no arithmetic on it.
- `req_valid_i` dropping while not granted is legal; the requester is simply not considered.

## Timing
- **Reset values:**
  - all outputs 0;
  - state = IDLE;
  - `ptr` = `NUM_REQ-1`, so requester 0 has top priority after reset;
  - operand, result and error registers 0;
  - watchdog counter 0.
- **Reset mid-operation:** abandon the operation with no response. A done arriving later is ignored because the state is IDLE.
- **Latency:**
  - accept in cycle t;
  - `mul_start_o` in cycle t+1;
  - WAIT from t+2;
  - if done is seen in cycle d, CAPTURE is at d+1 and `rsp_valid_o` rises at d+2.
- **Timeout:** `rsp_valid_o` with `rsp_error_o`=1 rises at t+2+TIMEOUT.
- **Back-to-back:** the next accept can happen no earlier than the cycle after the response handshake.
- **Fairness:** with every requester continuously valid, grants rotate strictly 0,1,…,NUM_REQ-1,0.

## Test plan
- **Single op:** requester 2 sends 7 × −3, with a real `mul_datapath` behind the block. Required: `mul_start_o` high exactly 1 cycle; `rsp_valid_o`=4'b0100 two cycles after done; `rsp_product_o`=0xFFFFFFFF_FFFFFFEB; `rsp_error_o`=0.
- **Round-robin:** all four requesters held valid with `rsp_ready_i` tied high. Required: grant order 0,1,2,3,0,1; `req_ready_o` always one-hot; no grant while `busy_o`=1.
- **Backpressure:** `rsp_ready_i` held low for 10 cycles in RESP. Required: `rsp_valid_o`, `rsp_product_o` and `rsp_error_o` stable; no new `req_ready_o`; IDLE is reached one cycle after `rsp_ready_i` rises.
- **Timeout:** `mul_done_i` tied 0 with `TIMEOUT`=32. Required: response at t+34 with `rsp_error_o`=1 and `rsp_product_o`=0. A done pulse injected afterwards in IDLE or RESP has no effect.
- **Reset mid-WAIT:** assert `rst_n`=0 for one cycle during WAIT, then present requesters 1 and 3. Required: all outputs 0 during reset; the first grant afterwards goes to requester 1.
- **Extremes:** requester 0 sends −2^31 × −2^31. Required: `rsp_product_o`=0x40000000_00000000.
